// File: rtl/pipe_hazard_ctrl.sv
// Purpose: pipeline hazard control for load-use stalls, taken-branch flushes and multi-cycle multiplies.
// Latency: stall/flush controls are combinational in the current cycle; state updates on the falling Clk edge.
// Backpressure: drops PCWrite/IF_ID_Write on a load-use hazard, and also ID_EX_Write while a multiply occupies EX.
module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  IF_ID_Rs,
  input  logic [4:0]  IF_ID_Rt,
  input  logic [4:0]  ID_EX_Rt,
  input  logic        ID_EX_MemRead,
  input  logic        ID_EX_MulOp,
  input  logic        BranchTaken,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_Write,
  output logic        ID_EX_Flush,
  output logic        IF_ID_Flush,
  output logic        MulBusy,
  output logic        HiLoWrite,
  output logic [15:0] StallCount
);

  typedef enum logic {IDLE, MUL} state_t;

  // The entry cycle counts as the first occupancy cycle; MUL then runs the remaining MUL_CYCLES-1.
  localparam logic [3:0] MulInit = 4'(MUL_CYCLES - 2);

  state_t     state;
  state_t     stateNext;
  logic [3:0] mulCnt;
  logic [3:0] mulCntNext;
  logic       loadHaz;

  // Load-use hazard: a load in EX writes a register that the instruction in ID reads ($0 never counts).
  assign loadHaz = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                   ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));

  // Next-state and pipeline control; reset holds the outputs at their free-running values.
  always_comb begin
    stateNext   = state;
    mulCntNext  = mulCnt;
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    ID_EX_Write = 1'b1;
    ID_EX_Flush = 1'b0;
    IF_ID_Flush = 1'b0;
    MulBusy     = 1'b0;
    HiLoWrite   = 1'b0;
    if (!Rst) begin
      case (state)
        IDLE: begin
          if (BranchTaken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
          end else if (ID_EX_MulOp) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Write = 1'b0;
            MulBusy     = 1'b1;
            stateNext   = MUL;
            mulCntNext  = MulInit;
          end else if (loadHaz) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
          end
        end
        MUL: begin
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          ID_EX_Write = 1'b0;
          MulBusy     = 1'b1;
          if (mulCnt == 4'd0) begin
            // Last occupancy cycle: commit Hi/Lo and let the next instruction into EX.
            HiLoWrite   = 1'b1;
            ID_EX_Write = 1'b1;
            stateNext   = IDLE;
          end else begin
            mulCntNext = mulCnt - 4'd1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // FSM and multiply counter advance on the falling edge, in step with the pipeline registers.
  always_ff @(negedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= IDLE;
      mulCnt <= 4'd0;
    end else begin
      state  <= stateNext;
      mulCnt <= mulCntNext;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(negedge Clk or posedge Rst) begin
    if (Rst) begin
      StallCount <= 16'd0;
    end else if (!PCWrite && (StallCount != 16'hFFFF)) begin
      StallCount <= StallCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  localparam int MUL_CYCLES = 4;

  logic        Clk;
  logic        Rst;
  logic [4:0]  IF_ID_Rs;
  logic [4:0]  IF_ID_Rt;
  logic [4:0]  ID_EX_Rt;
  logic        ID_EX_MemRead;
  logic        ID_EX_MulOp;
  logic        BranchTaken;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        ID_EX_Write;
  logic        ID_EX_Flush;
  logic        IF_ID_Flush;
  logic        MulBusy;
  logic        HiLoWrite;
  logic [15:0] StallCount;

  int errors = 0;
  int checks = 0;
  // Reference model: cycles of multiply occupancy still to run (including the current one) and stall total.
  int mulLeft = 0;
  int stallRef = 0;
  int hiloPulses = 0;

  pipe_hazard_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .Clk(Clk), .Rst(Rst),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .ID_EX_Rt(ID_EX_Rt),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MulOp(ID_EX_MulOp), .BranchTaken(BranchTaken),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
    .ID_EX_Flush(ID_EX_Flush), .IF_ID_Flush(IF_ID_Flush), .MulBusy(MulBusy),
    .HiLoWrite(HiLoWrite), .StallCount(StallCount)
  );

  initial begin
    Clk = 1'b1;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, compare at the rising edge, then advance the model.
  task automatic step(input logic rst, input logic br, input logic mulop, input logic memrd,
                      input logic [4:0] exRt, input logic [4:0] rs, input logic [4:0] rt,
                      input bit chk);
    logic ePC, eIFW, eIDW, eIDF, eIFF, eBusy, eHL;
    Rst = rst; BranchTaken = br; ID_EX_MulOp = mulop; ID_EX_MemRead = memrd;
    ID_EX_Rt = exRt; IF_ID_Rs = rs; IF_ID_Rt = rt;
    @(posedge Clk);
    ePC = 1'b1; eIFW = 1'b1; eIDW = 1'b1; eIDF = 1'b0; eIFF = 1'b0; eBusy = 1'b0; eHL = 1'b0;
    if (rst) begin
      mulLeft = 0;
      stallRef = 0;
    end else begin
      if (mulLeft == 0 && !br && mulop) mulLeft = MUL_CYCLES;
      if (mulLeft > 0) begin
        ePC = 1'b0; eIFW = 1'b0; eBusy = 1'b1;
        eIDW = (mulLeft == 1);
        eHL  = (mulLeft == 1);
      end else if (br) begin
        eIFF = 1'b1; eIDF = 1'b1;
      end else if (memrd && exRt != 5'd0 && (exRt == rs || exRt == rt)) begin
        ePC = 1'b0; eIFW = 1'b0; eIDF = 1'b1;
      end
    end
    if (chk) begin
      check("PCWrite", 16'(PCWrite), 16'(ePC));
      check("IF_ID_Write", 16'(IF_ID_Write), 16'(eIFW));
      check("ID_EX_Write", 16'(ID_EX_Write), 16'(eIDW));
      check("ID_EX_Flush", 16'(ID_EX_Flush), 16'(eIDF));
      check("IF_ID_Flush", 16'(IF_ID_Flush), 16'(eIFF));
      check("MulBusy", 16'(MulBusy), 16'(eBusy));
      check("HiLoWrite", 16'(HiLoWrite), 16'(eHL));
      check("StallCount", StallCount, 16'(stallRef));
    end
    if (HiLoWrite) hiloPulses++;
    @(negedge Clk);
    if (!rst) begin
      if (mulLeft > 0) mulLeft--;
      if (!ePC && stallRef < 65535) stallRef++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
  endtask

  initial begin
    Rst = 1'b1; BranchTaken = 1'b0; ID_EX_MulOp = 1'b0; ID_EX_MemRead = 1'b0;
    ID_EX_Rt = 5'd0; IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0;
    @(negedge Clk); #1;

    // Reset with hazard-looking inputs: outputs must stay at free-running values.
    step(1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    check("reset_stall", StallCount, 16'd0);

    // Load-use hazard on rs: exactly one stall cycle.
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b1);
    check("loaduse_stall", StallCount, 16'd1);
    idle(1);

    // Load writing $0 never stalls.
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd3, 5'd0, 1'b1);
    check("zero_reg_pc", 16'(PCWrite), 16'd1);
    check("zero_reg_stall", StallCount, 16'd1);

    // Single multiply: four busy cycles, HiLo commit on the last.
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    hiloPulses = 0;
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < MUL_CYCLES - 1; i++)
      step(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 1'b1);
    check("mul_stall", StallCount, 16'(MUL_CYCLES));
    check("mul_hilo_pulses", 16'(hiloPulses), 16'd1);
    idle(2);

    // Branch beats a simultaneous load hazard; no stall counted.
    step(1'b0, 1'b1, 1'b0, 1'b1, 5'd6, 5'd1, 5'd6, 1'b1);
    check("branch_stall", StallCount, 16'(MUL_CYCLES));

    // Reset in the second multiply cycle aborts without a HiLo commit.
    hiloPulses = 0;
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    check("abort_stall", StallCount, 16'd0);
    idle(MUL_CYCLES);
    check("abort_hilo_pulses", 16'(hiloPulses), 16'd0);

    // Back-to-back multiplies with no idle gap.
    hiloPulses = 0;
    for (int i = 0; i < 3 * MUL_CYCLES; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    check("b2b_hilo_pulses", 16'(hiloPulses), 16'd3);
    idle(1);

    // Randomized traffic with small register numbers so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'b1);
    end

    // Saturation: continuous multiplies hold the PC for more than 65536 cycles.
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < 65600; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("sat_stall", StallCount, 16'hFFFF);
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle(MUL_CYCLES);
    check("sat_hold", StallCount, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 4, sets the EX-stage occupancy of a multiply/madd/msub in cycles; legal range 2..15.
REQ-002 Clk  in  1  single clock; all state updates on the falling edge, the same edge as the pipeline registers.
REQ-003 Rst  in  1  asynchronous, active-high reset.
REQ-004 IF_ID_Rs  in  5  rs field of the instruction in ID.
REQ-005 IF_ID_Rt  in  5  rt field of the instruction in ID.
REQ-006 ID_EX_Rt  in  5  rt field of the instruction in EX.
REQ-007 ID_EX_MemRead  in  1  instruction in EX is a load.
REQ-008 ID_EX_MulOp  in  1  instruction in EX is mult/madd/msub (from MaddOut, MsubOut, HiWriteOut decode).
REQ-009 BranchTaken  in  1  branch resolved taken in EX this cycle.
REQ-010 PCWrite  out  1  PC update enable.
REQ-011 IF_ID_Write  out  1  IF/ID register load enable.
REQ-012 ID_EX_Write  out  1  ID/EX register load enable (0 = hold).
REQ-013 ID_EX_Flush  out  1  load all-zero control fields into ID/EX (bubble).
REQ-014 IF_ID_Flush  out  1  load a NOP into IF/ID.
REQ-015 MulBusy  out  1  multiply occupying EX.
REQ-016 HiLoWrite  out  1  one-cycle Hi/Lo commit strobe.
REQ-017 StallCount  out  16  saturating count of stall cycles since reset.

Function
REQ-018 FSM states: IDLE, MUL; counter MulCnt is 4 bits.
REQ-019 LoadHaz = ID_EX_MemRead & (ID_EX_Rt != 0) & (ID_EX_Rt == IF_ID_Rs | ID_EX_Rt == IF_ID_Rt); it is combinational.
REQ-020 In IDLE with no event: PCWrite=1, IF_ID_Write=1, ID_EX_Write=1, both flushes 0, MulBusy=0, HiLoWrite=0.
REQ-021 Priority in IDLE: BranchTaken > ID_EX_MulOp > LoadHaz.
REQ-022 BranchTaken in IDLE: IF_ID_Flush=1 and ID_EX_Flush=1 in the same cycle; PCWrite=1; the state stays IDLE.
REQ-023 LoadHaz in IDLE, without branch or MulOp: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 for that cycle only; the state stays IDLE.
REQ-024 ID_EX_MulOp in IDLE, without branch: at the next falling edge, state -> MUL and MulCnt <= MUL_CYCLES-2.
REQ-025 Outputs in that entry cycle: PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, MulBusy=1.
REQ-026 In MUL: PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, ID_EX_Flush=0, MulBusy=1; MulCnt decrements on each falling edge.
REQ-027 In MUL with MulCnt==0: HiLoWrite=1 and ID_EX_Write=1, so the next instruction enters EX; at the next edge state -> IDLE.
REQ-028 Total multiply occupancy of EX is exactly MUL_CYCLES cycles, with one HiLoWrite pulse per multiply.
REQ-029 BranchTaken, LoadHaz and ID_EX_MulOp are ignored while in MUL.
REQ-030 A MulOp still present in EX after the return to IDLE is a new multiply; back-to-back multiplies have no idle gap.
REQ-031 StallCount increments on each falling edge where PCWrite==0; it saturates at 16'hFFFF.

Reset
REQ-032 Rst=1 asynchronously forces state IDLE, MulCnt=0 and StallCount=0.
REQ-033 While Rst=1, outputs take the IDLE no-event values of REQ-020.
REQ-034 Rst asserted mid-MUL aborts the multiply with no HiLoWrite pulse.
REQ-035 After Rst deasserts, the first falling edge evaluates inputs normally.

Verification
REQ-036 Load-use: ID_EX_MemRead=1, ID_EX_Rt=5, IF_ID_Rs=5 -> one cycle with PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; StallCount=1.
REQ-037 Zero register: ID_EX_MemRead=1, ID_EX_Rt=0, IF_ID_Rt=0 -> no stall; PCWrite=1.
REQ-038 Multiply, MUL_CYCLES=4: ID_EX_MulOp=1 for one cycle -> MulBusy=1 for 4 cycles and HiLoWrite=1 on the 4th only; StallCount=4.
REQ-039 Branch plus load hazard in the same cycle -> IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1; StallCount unchanged.
REQ-040 Rst pulsed in the 2nd MUL cycle -> immediately MulBusy=0 and PCWrite=1; no HiLoWrite; StallCount=0.
REQ-041 Saturation: force 65536+ stall cycles -> StallCount holds at 16'hFFFF.
